line_window_buffer: RTL
=======================

LINE_WINDOW_BUFFER -- requirements
Module: line_window_buffer

Interface
REQ-001 SHALL have parameter WIDTH, default 320, pixels per image row.
REQ-002 SHALL have parameter HEIGHT, default 240, rows per frame.
REQ-003 SHALL have port clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n  input  1  synchronous, active-low reset.
REQ-005 SHALL have port sof  input  1  start-of-frame strobe, sampled every cycle.
REQ-006 SHALL have port pix_valid  input  1  pix_in carries a pixel this cycle.
REQ-007 SHALL have port pix_in  input  8  grey-level pixel, raster order, left to right.
REQ-008 SHALL have port row_top  output  8 x [0:WIDTH-1]  oldest row of window; drives the 3x3 threshold stage in1.
REQ-009 SHALL have port row_mid  output  8 x [0:WIDTH-1]  centre row; drives in2.
REQ-010 SHALL have port row_bot  output  8 x [0:WIDTH-1]  newest row; drives in3.
REQ-011 SHALL have port win_valid  output  1  one-cycle pulse: new 3-row window presented.
REQ-012 SHALL have port row_idx  output  $clog2(HEIGHT)  frame row index of row_mid.
REQ-013 SHALL have port frame_done  output  1  one-cycle pulse after last window of frame.
REQ-014 SHALL have port busy  output  1  high in FILL or STREAM.

Function
REQ-015 SHALL implement states IDLE, FILL, STREAM, DONE.
REQ-016 SHALL, in IDLE and DONE, ignore pix_valid unless sof is high the same cycle.
REQ-017 SHALL, on sof in any state, clear column counter and rows-completed counter, discard any partial row, and enter FILL; a pix_valid in that same cycle is column 0 of row 0.
REQ-018 SHALL write each accepted pixel into an internal assembly line at the current column, then increment the column counter.
REQ-019 SHALL, when the pixel at column WIDTH-1 is accepted, on the same edge load row_bot with the completed line (including that pixel), row_mid with old row_bot, row_top with old row_mid, reset column to 0, increment rows-completed.
REQ-020 SHALL hold row_top/row_mid/row_bot stable between row completions.
REQ-021 SHALL move FILL to STREAM when rows-completed reaches 3.
REQ-022 SHALL assert win_valid for exactly one cycle, the cycle after each row completion that brings rows-completed to 3 or more; never during FILL with fewer than 3 rows.
REQ-023 SHALL set row_idx = rows-completed - 2 while win_valid is high (first window row_idx = 1, last = HEIGHT-2); hold it otherwise.
REQ-024 SHALL, when rows-completed reaches HEIGHT, assert frame_done coincident with that final win_valid and enter DONE.
REQ-025 SHALL not advance the column counter on cycles with pix_valid low; gaps of any length are allowed.
REQ-026 SHALL never let the column counter exceed WIDTH-1 or rows-completed exceed HEIGHT.

Reset
REQ-027 SHALL, while rst_n is low at a clock edge, set state IDLE, counters 0, all row_top/row_mid/row_bot pixels 0, win_valid 0, frame_done 0, busy 0, row_idx 0.
REQ-028 SHALL give rst_n priority over sof and pix_valid; reset mid-row discards the partial row.
REQ-029 SHALL accept no pixel before the first sof after reset.

Verification (WIDTH=4, HEIGHT=5)
REQ-030 Reset then 20 pix_valid cycles without sof -> win_valid never asserts, busy=0, rows all zero.
REQ-031 sof+pixels 1..12 back-to-back -> single win_valid the cycle after pixel 12; row_top={1,2,3,4}, row_mid={5,6,7,8}, row_bot={9,10,11,12}, row_idx=1.
REQ-032 Full frame of 20 pixels with pix_valid toggling every other cycle -> win_valid for rows 3,4,5 with row_idx 1,2,3; frame_done with third pulse; state DONE, busy=0.
REQ-033 sof after 6 pixels of a frame, then 12 pixels 100..111 -> first window row_top={100..103}; the 6 stale pixels never appear.
REQ-034 rst_n low for one cycle after 10 pixels -> all outputs 0 next cycle; further pixels ignored until sof.
REQ-035 In DONE, pixels without sof -> outputs unchanged; sof with pix_valid same cycle -> that pixel lands at row 0 column 0 of new frame.

Source files
------------

// File: rtl/line_window_buffer_if.sv
// Pixel stream in, three-row window out, between the line buffer and the 3x3 stage.
//   sof, pix_valid, pix_in           : raster pixel stream (master -> slave)
//   row_top/row_mid/row_bot          : oldest/centre/newest complete rows (slave -> master)
//   win_valid, row_idx, frame_done   : window strobe, centre-row index, end-of-frame strobe
//   busy                             : frame in progress
interface line_window_buffer_if #(
  parameter int unsigned WIDTH  = 320,
  parameter int unsigned HEIGHT = 240
) ();
  localparam int unsigned IW = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;

  logic          sof;
  logic          pix_valid;
  logic [7:0]    pix_in;
  logic [7:0]    row_top [0:WIDTH-1];
  logic [7:0]    row_mid [0:WIDTH-1];
  logic [7:0]    row_bot [0:WIDTH-1];
  logic          win_valid;
  logic [IW-1:0] row_idx;
  logic          frame_done;
  logic          busy;

  modport master (
    output sof, pix_valid, pix_in,
    input  row_top, row_mid, row_bot, win_valid, row_idx, frame_done, busy
  );

  modport slave (
    input  sof, pix_valid, pix_in,
    output row_top, row_mid, row_bot, win_valid, row_idx, frame_done, busy
  );
endinterface

// File: rtl/line_window_buffer.sv
// Assembles a raster pixel stream into full rows and presents a sliding
// three-row window (top = oldest, bot = newest) to a 3x3 neighbourhood stage.
//   clk   : sole clock, rising edge
//   rst_n : synchronous active-low reset
//   bus   : line_window_buffer_if.slave (pixel stream in, window out)
module line_window_buffer #(
  parameter int unsigned WIDTH  = 320,
  parameter int unsigned HEIGHT = 240
) (
  input  logic                clk,
  input  logic                rst_n,
  line_window_buffer_if.slave bus
);

  localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int unsigned RW = $clog2(HEIGHT + 1);
  localparam int unsigned IW = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;

  typedef enum logic [1:0] {IDLE, FILL, STREAM, DONE} state_t;

  state_t        state, state_next;
  logic [CW-1:0] col;
  logic [RW-1:0] rows;
  logic [7:0]    line_q [0:WIDTH-1];
  logic [7:0]    top_q  [0:WIDTH-1];
  logic [7:0]    mid_q  [0:WIDTH-1];
  logic [7:0]    bot_q  [0:WIDTH-1];
  logic          win_q, done_q, busy_q;
  logic [IW-1:0] idx_q;

  logic          accept_c, line_done_c;
  logic [CW-1:0] col_base_c;
  logic [RW-1:0] rows_inc_c;
  logic          win_next, done_next, busy_next;

  // sof restarts the frame in the same cycle, so its pixel is column 0 of row 0
  always_comb begin
    col_base_c  = bus.sof ? '0 : col;
    rows_inc_c  = (bus.sof ? '0 : rows) + RW'(1);
    accept_c    = bus.pix_valid &&
                  (bus.sof || (state == FILL) || (state == STREAM));
    line_done_c = accept_c && (col_base_c == CW'(WIDTH - 1));
  end

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  // Next state and next-cycle strobes
  always_comb begin
    state_next = state;
    win_next   = 1'b0;
    done_next  = 1'b0;
    if (bus.sof) state_next = FILL;
    if (line_done_c) begin
      if (rows_inc_c >= RW'(3)) win_next = 1'b1;
      if (rows_inc_c == RW'(HEIGHT)) begin
        done_next  = 1'b1;
        state_next = DONE;
      end else if (rows_inc_c >= RW'(3)) begin
        state_next = STREAM;
      end
    end
    busy_next = (state_next == FILL) || (state_next == STREAM);
  end

  // Counters, window rows and registered outputs
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      col    <= '0;
      rows   <= '0;
      win_q  <= 1'b0;
      done_q <= 1'b0;
      busy_q <= 1'b0;
      idx_q  <= '0;
      for (int i = 0; i < int'(WIDTH); i++) begin
        top_q[i] <= '0;
        mid_q[i] <= '0;
        bot_q[i] <= '0;
      end
    end else begin
      win_q  <= win_next;
      done_q <= done_next;
      busy_q <= busy_next;
      if (bus.sof) begin
        col  <= '0;
        rows <= '0;
      end
      if (accept_c) begin
        if (line_done_c) begin
          col  <= '0;
          rows <= rows_inc_c;
          // Completed line includes the pixel arriving this cycle
          for (int i = 0; i < int'(WIDTH); i++) begin
            top_q[i] <= mid_q[i];
            mid_q[i] <= bot_q[i];
            bot_q[i] <= (i == int'(WIDTH) - 1) ? bus.pix_in : line_q[i];
          end
          if (win_next) idx_q <= IW'(rows_inc_c - RW'(2));
        end else begin
          col <= col_base_c + CW'(1);
        end
      end
    end
  end

  // Assembly line: stale contents are harmless, every column is rewritten per row
  always_ff @(posedge clk) begin
    if (accept_c) line_q[col_base_c] <= bus.pix_in;
  end

  assign bus.row_top    = top_q;
  assign bus.row_mid    = mid_q;
  assign bus.row_bot    = bot_q;
  assign bus.win_valid  = win_q;
  assign bus.frame_done = done_q;
  assign bus.busy       = busy_q;
  assign bus.row_idx    = idx_q;

endmodule
